// File: rtl/bytewrite_ram.sv
// bytewrite_ram: single-port word RAM with per-byte write strobes and a range-error flag.
//   clk_i    rising-edge clock
//   rstn_i   asynchronous reset, active high (legacy name)
//   req_i    access request
//   we_i     byte write strobes, all zero selects a read
//   addr_i   byte address, bits [1:0] ignored for indexing
//   wdata_i  lane-aligned write data
//   rdata_o  registered read data
//   rvalid_o one-cycle pulse after each accepted request
//   err_o    pulses with rvalid_o when the request was out of range
// Optional build macro BYTEWRITE_RAM_WRITE_FIRST_EN: a write returns the
// post-write word on rdata_o instead of the pre-write word.
module bytewrite_ram #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_SIZE_WORDS = 1024
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req_i,
    input  logic [3:0]            we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  err_o
);
    localparam int IW = $clog2(MEM_SIZE_WORDS);

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE_WORDS];
    logic [IW-1:0]         idx;
    logic                  oor;
    logic [DATA_WIDTH-1:0] rd_word;

    assign idx = addr_i[IW+1:2];
    // any address bit above the word index makes the access out of range
    assign oor = (addr_i >> (IW + 2)) != '0;

    always_comb begin
        rd_word = mem[idx];
`ifdef BYTEWRITE_RAM_WRITE_FIRST_EN
        for (int k = 0; k < 4; k++)
            if (we_i[k]) rd_word[8*k +: 8] = wdata_i[8*k +: 8];
`endif
    end

    // The array shares the reset process so a write presented while reset is
    // high is dropped; the reset branch never touches the contents.
    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            err_o    <= req_i && oor;
            if (req_i) rdata_o <= oor ? '0 : rd_word;
            if (req_i && !oor)
                for (int k = 0; k < 4; k++)
                    if (we_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
    end
endmodule

// File: tb/tb_bytewrite_ram.sv
// tb_bytewrite_ram: randomized and directed check of bytewrite_ram against a byte-level memory model.
//   Drives inputs on the falling edge and samples outputs 1 time unit after the rising edge.
module tb_bytewrite_ram;
    logic        clk_i  = 1'b0;
    logic        rstn_i = 1'b1;
    logic        req_i  = 1'b0;
    logic [3:0]  we_i   = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        err_o;

    bytewrite_ram dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  ref_mem [4096];
    bit          known   [4096];
    logic [31:0] last_rd  = '0;
    logic [31:0] last_msk = '1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one request (or idle cycle when req=0), checked against the byte-array model
    task automatic xfer(input logic req, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
        logic [31:0] exp_rd, msk, old_w, new_w;
        logic        exp_err;
        int          base;
        @(negedge clk_i);
        req_i = req; we_i = we; addr_i = addr; wdata_i = wd;
        exp_err = req && (addr >= 32'd4096);
        exp_rd = last_rd;
        msk = last_msk;
        if (req && exp_err) begin
            exp_rd = '0;
            msk = '1;
        end else if (req) begin
            base = int'(addr & 32'hFFC);
            msk = '0;
            for (int b = 0; b < 4; b++) begin
                old_w[8*b +: 8] = ref_mem[base + b];
                new_w[8*b +: 8] = we[b] ? wd[8*b +: 8] : ref_mem[base + b];
`ifdef BYTEWRITE_RAM_WRITE_FIRST_EN
                msk[8*b +: 8] = (known[base + b] || we[b]) ? 8'hFF : 8'h00;
`else
                msk[8*b +: 8] = known[base + b] ? 8'hFF : 8'h00;
`endif
            end
`ifdef BYTEWRITE_RAM_WRITE_FIRST_EN
            exp_rd = new_w;
`else
            exp_rd = old_w;
`endif
            for (int b = 0; b < 4; b++) begin
                ref_mem[base + b] = new_w[8*b +: 8];
                if (we[b]) known[base + b] = 1'b1;
            end
        end
        last_rd = exp_rd;
        last_msk = msk;
        @(posedge clk_i);
        #1;
        check({tag, " rvalid"}, {31'd0, rvalid_o}, {31'd0, req});
        check({tag, " err"}, {31'd0, err_o}, {31'd0, exp_err});
        check({tag, " rdata"}, rdata_o & msk, exp_rd & msk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rdata"}, rdata_o, 32'h0);
        check({tag, " rvalid"}, {31'd0, rvalid_o}, 32'h0);
        check({tag, " err"}, {31'd0, err_o}, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = 8'h00;
            known[i] = 1'b0;
        end
        #1 check_zero("reset_t0");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i);
            #1 check_zero("reset_hold");
        end
        @(negedge clk_i);
        rstn_i = 1'b0;
        @(posedge clk_i);
        #1 check_zero("reset_release");

        xfer(1, 4'b1111, 32'h10, 32'h0000055C, "wr10");
        xfer(1, 4'b0000, 32'h10, 32'h0, "rd10");
        check("rd10 const", rdata_o, 32'h0000055C);

        xfer(1, 4'b1111, 32'h20, 32'hAABBCCDD, "wr20");
        xfer(1, 4'b0101, 32'h20, 32'h11223344, "merge20");
        xfer(1, 4'b0000, 32'h20, 32'h0, "rd20");
        check("merge const", rdata_o, 32'hAA22CC44);

        xfer(1, 4'b0001, 32'h20, 32'hFFFFFFFF, "rdw20");
`ifdef BYTEWRITE_RAM_WRITE_FIRST_EN
        check("rdw const", rdata_o, 32'hAA22CCFF);
`else
        check("rdw const", rdata_o, 32'hAA22CC44);
`endif

        xfer(1, 4'b1111, 32'h0, 32'h12345678, "wr0");
        xfer(1, 4'b1111, 32'd4096, 32'hDEADBEEF, "oor_wr");
        check("oor err const", {31'd0, err_o}, 32'h1);
        check("oor rdata const", rdata_o, 32'h0);
        xfer(1, 4'b0000, 32'h0, 32'h0, "rd0_after_oor");
        check("rd0 const", rdata_o, 32'h12345678);
        xfer(0, 4'b0000, 32'h0, 32'h0, "idle1");
        xfer(0, 4'b1111, 32'h24, 32'h0, "idle2");
        xfer(1, 4'b0000, 32'hFFE, 32'h0, "rd_top");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0)
                a = $urandom | 32'h0000_1000;
            else
                a = ($urandom_range(0, 1) ? 32'hFC0 : 32'h0)
                    + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            xfer($urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) == 0 ? 4'b0000 : 4'($urandom),
                 a, $urandom, "rand");
        end

        xfer(1, 4'b1111, 32'h40, 32'hCAFEF00D, "wr40");
        xfer(1, 4'b0000, 32'h40, 32'h0, "burst_rd");
        #1 rstn_i = 1'b1;
        #1 check_zero("async_reset");
        req_i = 1'b1; we_i = 4'b1111; addr_i = 32'h40; wdata_i = 32'h0BAD0BAD;
        @(posedge clk_i);
        #1 check_zero("reset_hold_write");
        @(negedge clk_i);
        req_i = 1'b0; we_i = '0;
        rstn_i = 1'b0;
        last_rd = '0;
        last_msk = '1;
        xfer(0, 4'b0000, 32'h0, 32'h0, "post_reset_idle");
        xfer(1, 4'b0000, 32'h40, 32'h0, "rd40_after_reset");
        check("rd40 const", rdata_o, 32'hCAFEF00D);
        xfer(1, 4'b0000, 32'h10, 32'h0, "rd10_after_reset");
        xfer(0, 4'b0000, 32'h0, 32'h0, "final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
